// File: rtl/exc_arbiter_pkg.sv
// Shared constants and types for the CP0 exception arbiter.
// Optional feature macro: EXC_TRAP_EN (tr cause takes part in arbitration).
package exc_arbiter_pkg;

    // ExcCode values driven onto exception_type_o
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    // Cause flag bit positions; lower index = higher priority
    localparam int FLAG_W    = 9;
    localparam int F_ADEL_IF = 0;
    localparam int F_RI      = 1;
    localparam int F_SYS     = 2;
    localparam int F_BP      = 3;
    localparam int F_OV      = 4;
    localparam int F_TR      = 5;
    localparam int F_ADEL_D  = 6;
    localparam int F_ADES    = 7;
    localparam int F_ERET    = 8;

    localparam logic [4:0]  CP0_REG_EPC    = 5'd14;
    localparam logic [31:0] EXC_VECTOR_OFS = 32'h180;

    // Flags that are allowed to reach the priority encoders
`ifdef EXC_TRAP_EN
    localparam logic [FLAG_W-1:0] FLAG_MASK = 9'h1FF;
`else
    localparam logic [FLAG_W-1:0] FLAG_MASK = 9'h1DF;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [4:0] code;
    } prio_t;

    function automatic logic [4:0] flag_code(input int idx);
        logic [4:0] code;
        case (idx)
            F_ADEL_IF: code = EXC_ADEL;
            F_RI:      code = EXC_RI;
            F_SYS:     code = EXC_SYS;
            F_BP:      code = EXC_BP;
            F_OV:      code = EXC_OV;
            F_TR:      code = EXC_TR;
            F_ADEL_D:  code = EXC_ADEL;
            F_ADES:    code = EXC_ADES;
            F_ERET:    code = EXC_ERET;
            default:   code = EXC_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/exc_arbiter_prio_enc.sv
// Per-slot cause priority encoder: flag vector in, {hit, ExcCode} out.
// Optional feature macro: EXC_TRAP_EN (masking is applied by the caller).
module exc_prio_enc
    import exc_arbiter_pkg::*;
(
    input  logic [FLAG_W-1:0] flags_i,
    output prio_t             prio_o
);

    // Scan high to low so the lowest set index wins
    always_comb begin
        prio_o = '0;
        for (int i = FLAG_W - 1; i >= 0; i--) begin
            if (flags_i[i]) begin
                prio_o.hit  = 1'b1;
                prio_o.code = flag_code(i);
            end
        end
    end

endmodule

// File: rtl/exc_arbiter.sv
// Exception arbiter/sequencer at the MEM/commit boundary of the dual-issue core.
// Optional feature macro: EXC_TRAP_EN (tr cause arbitrates with code 0d).
module exc_arbiter
    import exc_arbiter_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              slot1_valid_i,
    input  logic              slot2_valid_i,
    input  logic [FLAG_W-1:0] slot1_exc_i,
    input  logic [FLAG_W-1:0] slot2_exc_i,
    input  logic [31:0]       status_i,
    input  logic [31:0]       cause_i,
    input  logic [31:0]       epc_i,
    input  logic [31:0]       ebase_i,
    input  logic              cp0_we_i,
    input  logic [4:0]        cp0_waddr_i,
    input  logic [2:0]        cp0_wsel_i,
    input  logic [31:0]       cp0_wdata_i,
    output logic              exception_flag_o,
    output logic [4:0]        exception_type_o,
    output logic              exception_first_inst_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [31:0]       redirect_pc_o,
    output logic              busy_o
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              int_q, int_d;

    logic              int_req;
    logic [FLAG_W-1:0] s1_flags;
    logic [FLAG_W-1:0] s2_flags;
    prio_t             s1_prio;
    prio_t             s2_prio;
    logic              int_take;
    logic              s1_take;
    logic              s2_take;
    logic              any_take;
    logic [4:0]        exc_code;
    logic              epc_fwd;
    logic [31:0]       target_pc;

    logic              unused_ok;
    assign unused_ok = ^{status_i[31:16], status_i[7:2],
                         cause_i[31:16], cause_i[7:0]};

    assign int_req = status_i[0] & ~status_i[1]
                   & (|(cause_i[15:8] & status_i[15:8]));

    // Mask disabled causes and apply slot qualification
    always_comb begin
        s1_flags = '0;
        s2_flags = '0;
        if (slot1_valid_i) begin
            s1_flags = slot1_exc_i & FLAG_MASK;
        end
        if (slot1_valid_i && slot2_valid_i) begin
            s2_flags = slot2_exc_i & FLAG_MASK;
        end
    end

    exc_prio_enc u_enc_slot1 (
        .flags_i (s1_flags),
        .prio_o  (s1_prio)
    );

    exc_prio_enc u_enc_slot2 (
        .flags_i (s2_flags),
        .prio_o  (s2_prio)
    );

    // Pick the oldest excepting instruction and its redirect target
    always_comb begin
        int_take = int_q & slot1_valid_i;
        s1_take  = s1_prio.hit;
        s2_take  = s2_prio.hit & ~s1_prio.hit;
        any_take = int_take | s1_take | s2_take;

        exc_code = s2_prio.code;
        if (int_take) begin
            exc_code = EXC_INT;
        end else if (s1_take) begin
            exc_code = s1_prio.code;
        end

        epc_fwd = cp0_we_i
                & (cp0_waddr_i == CP0_REG_EPC)
                & (cp0_wsel_i == 3'd0);

        target_pc = ebase_i + EXC_VECTOR_OFS;
        if (exc_code == EXC_ERET) begin
            target_pc = epc_fwd ? cp0_wdata_i : epc_i;
        end
    end

    // Next-state and commit outputs; everything quiet while in reset
    always_comb begin
        state_d                = state_q;
        cnt_d                  = cnt_q;
        int_d                  = int_req;
        exception_flag_o       = 1'b0;
        exception_type_o       = 5'h00;
        exception_first_inst_o = 1'b0;
        flush_o                = 1'b0;
        redirect_o             = 1'b0;
        redirect_pc_o          = 32'h0;
        busy_o                 = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (!stall_i && any_take) begin
                        exception_flag_o       = 1'b1;
                        exception_type_o       = exc_code;
                        exception_first_inst_o = int_take | s1_take;
                        flush_o                = 1'b1;
                        redirect_o             = 1'b1;
                        redirect_pc_o          = target_pc;
                        state_d                = ST_DRAIN;
                        cnt_d                  = CNT_INIT;
                        int_d                  = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    busy_o = 1'b1;
                    if (!stall_i) begin
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, drain counter and registered interrupt request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
        end
    end

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter with a cycle-level reference model.
// Honours EXC_TRAP_EN the same way the design does.
module tb_exc_arbiter;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        s1v = 1'b0;
    logic        s2v = 1'b0;
    logic [8:0]  s1e = '0;
    logic [8:0]  s2e = '0;
    logic [31:0] status = '0;
    logic [31:0] cause = '0;
    logic [31:0] epc = '0;
    logic [31:0] ebase = '0;
    logic        cp0_we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [2:0]  wsel = '0;
    logic [31:0] wdata = '0;

    logic        flag;
    logic [4:0]  etype;
    logic        first;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        busy;

    int total = 0;
    int bad = 0;

    exc_arbiter #(.DRAIN_CYCLES(D)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall_i                (stall),
        .slot1_valid_i          (s1v),
        .slot2_valid_i          (s2v),
        .slot1_exc_i            (s1e),
        .slot2_exc_i            (s2e),
        .status_i               (status),
        .cause_i                (cause),
        .epc_i                  (epc),
        .ebase_i                (ebase),
        .cp0_we_i               (cp0_we),
        .cp0_waddr_i            (waddr),
        .cp0_wsel_i             (wsel),
        .cp0_wdata_i            (wdata),
        .exception_flag_o       (flag),
        .exception_type_o       (etype),
        .exception_first_inst_o (first),
        .flush_o                (flush),
        .redirect_o             (redir),
        .redirect_pc_o          (rpc),
        .busy_o                 (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Cause codes listed from highest to lowest priority
    logic [4:0] codes [9] = '{5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c,
                              5'h0d, 5'h04, 5'h05, 5'h0e};

    function automatic logic [5:0] arb(input logic [8:0] f);
        for (int i = 0; i < 9; i++) begin
            if (f[i]) return {1'b1, codes[i]};
        end
        return 6'd0;
    endfunction

    // Reference model state
    bit          m_int = 1'b0;
    int          m_hold = 0;

    logic [8:0]  m_mask;
    logic [8:0]  m_f1;
    logic [8:0]  m_f2;
    logic [5:0]  m_a1;
    logic [5:0]  m_a2;
    logic        m_ti;
    logic        m_fire;
    logic [4:0]  m_ty;
    logic        m_first;
    logic [31:0] m_pc;
    logic        m_irq;

    always @(negedge clk) begin
`ifdef EXC_TRAP_EN
        m_mask = 9'h1FF;
`else
        m_mask = 9'h1DF;
`endif
        m_f1 = s1v ? (s1e & m_mask) : 9'h0;
        m_f2 = (s1v && s2v && m_f1 == 9'h0) ? (s2e & m_mask) : 9'h0;
        m_a1 = arb(m_f1);
        m_a2 = arb(m_f2);
        m_ti = m_int && s1v;
        m_fire = !rst && m_hold == 0 && !stall
              && (m_ti || m_a1[5] || m_a2[5]);
        m_ty = m_ti ? 5'h00 : (m_a1[5] ? m_a1[4:0] : m_a2[4:0]);
        m_first = m_ti || m_a1[5];
        if (m_ty == 5'h0e)
            m_pc = (cp0_we && waddr == 5'd14 && wsel == 3'd0) ? wdata : epc;
        else
            m_pc = ebase + 32'h180;

        chk("m_flag", flag, m_fire);
        chk("m_type", etype, m_fire ? m_ty : 5'h0);
        chk("m_first", first, m_fire && m_first);
        chk("m_flush", flush, m_fire);
        chk("m_redir", redir, m_fire);
        chk("m_pc", rpc, m_fire ? m_pc : 32'h0);
        chk("m_busy", busy, !rst && m_hold > 0);

        m_irq = status[0] && !status[1] && |(status[15:8] & cause[15:8]);
        if (rst) begin
            m_int = 1'b0;
            m_hold = 0;
        end else begin
            m_int = m_fire ? 1'b0 : m_irq;
            if (m_fire) m_hold = D;
            else if (m_hold > 0 && !stall) m_hold--;
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        s1v = 0; s2v = 0; s1e = '0; s2e = '0;
        cp0_we = 0; waddr = '0; wsel = '0; wdata = '0;
        stall = 0;
    endtask

    task automatic drain();
        adv(); clr(); adv(); adv();
    endtask

    logic        x_flag;
    logic [4:0]  x_type;
    logic        x_first;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        clr();
        ebase = 32'hBFC00200;
        s1v = 1; s1e = 9'h002;
        smp();
        chk("rst_flag", flag, 0);
        chk("rst_pc", rpc, 0);
        chk("rst_busy", busy, 0);
        adv(); adv();
        rst = 0; clr();

        // ri|ov on slot1
        adv(); s1v = 1; s1e = 9'h012;
        smp();
        chk("t1_type", etype, 5'h0a);
        chk("t1_first", first, 1);
        chk("t1_pc", rpc, 32'hBFC00380);
        chk("t1_flush", flush, 1);
        adv(); clr(); smp();
        chk("t1_busy1", busy, 1);
        adv(); smp();
        chk("t1_busy2", busy, 1);
        adv(); smp();
        chk("t1_busy3", busy, 0);

        // slot2 ades, then ignored / accepted slot1 adel_if
        adv(); s1v = 1; s2v = 1; s2e = 9'h080;
        smp();
        chk("t2_type", etype, 5'h05);
        chk("t2_first", first, 0);
        adv(); s2v = 0; s2e = '0; s1e = 9'h001;
        smp();
        chk("t2_ign1", flag, 0);
        adv(); smp();
        chk("t2_ign2", flag, 0);
        adv(); smp();
        chk("t2_take", flag, 1);
        chk("t2_type2", etype, 5'h04);
        drain();

        // eret with forwarded EPC write from slot1
        adv(); s1v = 1; s2v = 1; s2e = 9'h100;
        cp0_we = 1; waddr = 5'd14; wsel = 3'd0;
        wdata = 32'h80001000; epc = 32'h0;
        smp();
        chk("t3_pc", rpc, 32'h80001000);
        chk("t3_type", etype, 5'h0e);
        drain();

        // eret where the write is a different select: no forwarding
        adv(); s1v = 1; s2v = 1; s2e = 9'h100;
        cp0_we = 1; waddr = 5'd14; wsel = 3'd1;
        wdata = 32'h80001000; epc = 32'h00002468;
        smp();
        chk("t3b_pc", rpc, 32'h00002468);
        drain();

        // interrupt latency
        adv(); status = 32'h0000_0401; cause = 32'h0000_0400; s1v = 1;
        smp();
        chk("t4_early", flag, 0);
        adv(); smp();
        chk("t4_flag", flag, 1);
        chk("t4_type", etype, 5'h00);
        chk("t4_pc", rpc, 32'hBFC00380);
        adv(); status = '0; cause = '0; clr(); adv(); adv();

        // pending interrupt waits for slot1, then beats eret
        adv(); status = 32'h0000_0401; cause = 32'h0000_0400;
        smp();
        adv(); smp();
        chk("t4b_wait", flag, 0);
        adv(); s1v = 1; s1e = 9'h100; status = '0; cause = '0;
        smp();
        chk("t4b_type", etype, 5'h00);
        chk("t4b_first", first, 1);
        chk("t4b_pc", rpc, 32'hBFC00380);
        drain();

        // EXL masks interrupts
        adv(); status = 32'h0000_0403; cause = 32'h0000_0400; s1v = 1;
        smp();
        adv(); smp();
        chk("t4c_exl", flag, 0);
        adv(); status = '0; cause = '0; clr();

        // stall before and during drain
        adv(); s1v = 1; s1e = 9'h004; stall = 1;
        smp(); chk("t5_st1", flag, 0);
        adv(); smp(); chk("t5_st2", flag, 0);
        adv(); smp(); chk("t5_st3", flag, 0);
        adv(); stall = 0;
        smp();
        chk("t5_flag", flag, 1);
        chk("t5_type", etype, 5'h08);
        adv(); clr(); stall = 1;
        adv(); adv(); stall = 0;
        smp(); chk("t5_busy", busy, 1);
        adv(); smp(); chk("t5_busy2", busy, 1);
        adv(); smp(); chk("t5_idle", busy, 0);

        // tr-only on slot1
`ifdef EXC_TRAP_EN
        x_flag = 1; x_type = 5'h0d; x_first = 1;
`else
        x_flag = 0; x_type = 5'h00; x_first = 0;
`endif
        adv(); s1v = 1; s1e = 9'h020;
        smp();
        chk("t6_flag", flag, x_flag);
        chk("t6_type", etype, x_type);
        drain();

        // tr on slot1 alongside ades on slot2
`ifdef EXC_TRAP_EN
        x_type = 5'h0d; x_first = 1;
`else
        x_type = 5'h05; x_first = 0;
`endif
        adv(); s1v = 1; s1e = 9'h020; s2v = 1; s2e = 9'h080;
        smp();
        chk("t6b_type", etype, x_type);
        chk("t6b_first", first, x_first);
        drain();

        // reset in the middle of drain
        adv(); s1v = 1; s1e = 9'h040;
        smp();
        chk("t7_type", etype, 5'h04);
        adv(); clr(); rst = 1;
        smp();
        chk("t7_rbusy", busy, 0);
        adv(); rst = 0; s1v = 1; s1e = 9'h008;
        smp();
        chk("t7_flag", flag, 1);
        chk("t7_type2", etype, 5'h09);
        drain();

        // slot1 priority among several flags; slot2 shadowed
        adv(); s1v = 1; s1e = 9'h0C8; s2v = 1; s2e = 9'h001;
        smp();
        chk("t8_type", etype, 5'h09);
        chk("t8_first", first, 1);
        drain();

        // slot2 without a valid slot1 never commits
        adv(); s2v = 1; s2e = 9'h002;
        smp();
        chk("t8_s2only", flag, 0);
        adv(); clr();
        adv(); adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_arbiter.md
# exc_arbiter

Exception arbiter and sequencer for the dual-issue pipeline's coprocessor-0 register file.
- Sits at the MEM/commit boundary and collects per-slot exception causes and the interrupt request.
- Selects the single architecturally oldest exception and drives the CP0 commit strobe, type and slot select.
- Issues the pipeline flush and PC redirect, then holds off new commits while wrong-path instructions drain.

## Interface
Parameters:
- DRAIN_CYCLES, 2: cycles after a commit during which the slot exception inputs are ignored; legal range 1–7.

Ports (clock and reset first):
- clk  in  1  core clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  MEM stage stalled; no commit this cycle.
- slot1_valid_i / slot2_valid_i  in  1 each  slot holds a real instruction.
- slot1_exc_i / slot2_exc_i  in  9 each  cause flags, one-hot-or-more. Bit order from 0 to 8: adel_if, ri, sys, bp, ov, tr, adel_d, ades, eret.
- status_i  in  32  CP0 Status; IE = bit 0, EXL = bit 1, IM = [15:8].
- cause_i  in  32  CP0 Cause; IP = [15:8].
- epc_i  in  32  CP0 EPC.
- ebase_i  in  32  CP0 EBase.
- cp0_we_i  in  1  a CP0 write commits this cycle.
- cp0_waddr_i  in  5  register number of that write.
- cp0_wsel_i  in  3  select of that write.
- cp0_wdata_i  in  32  data of that write.
- exception_flag_o  out  1  CP0 commit strobe.
- exception_type_o  out  5  ExcCode, or ERET code 5'h0e.
- exception_first_inst_o  out  1  1 = slot1 is the excepting instruction, 0 = slot2.
- flush_o  out  1  kill IF..MEM.
- redirect_o  out  1  load redirect_pc_o into the PC.
- redirect_pc_o  out  32  new fetch address.
- busy_o  out  1  drain state active.

## Operation
- Interrupt request: int_req = IE & ~EXL & |(IP & IM). It is registered into int_q every cycle, including while stalled. int_q is cleared by reset and by any commit.
- Slot qualification:
  - Slot1 participates if slot1_valid_i.
  - Slot2 participates only if slot1_valid_i & slot2_valid_i and slot1 has no flag set.
- Interrupts attach to slot1 if it is valid. Otherwise there is no commit and int_q persists.
- Per-slot priority, highest first: adel_if(04), ri(0a), sys(08), bp(09), ov(0c), tr(0d), adel_d(04), ades(05), eret(0e).
- An interrupt (type 00) on slot1 beats every slot flag.
- FSM states:
  - IDLE: commit when (int_q & slot1_valid_i) or a qualified flag is present, and ~stall_i. A commit is a single cycle asserting exception_flag_o, flush_o and redirect_o, plus type and slot select. The FSM then moves to DRAIN with cnt = DRAIN_CYCLES-1.
  - DRAIN: all outputs except busy_o are 0, and slot inputs are ignored. cnt decrements each non-stalled cycle. At cnt == 0 with ~stall_i, the FSM returns to IDLE.
- Redirect target:
  - ERET: EPC, with forwarding. If cp0_we_i and addr 14 and sel 0 in the commit cycle, the target is cp0_wdata_i; otherwise it is epc_i.
  - Any other exception: ebase_i + 32'h180 (32-bit add, wrap ignored).
- exception_first_inst_o is 1 for an interrupt and for any slot1 flag; it is 0 for a slot2 flag.

## Timing
- Commit outputs are combinational from inputs and state, and are valid in the same cycle the instruction sits in MEM. CP0 samples them at the next edge.
- Interrupt latency: pending bits at edge N → int_q at N+1 → commit in cycle N+1 at the earliest.
- Back-to-back commits: two commits are separated by at least DRAIN_CYCLES+1 cycles.
- Reset: state IDLE, cnt 0, int_q 0. All outputs are 0 while rst is high, including redirect_pc_o.
- Reset mid-DRAIN returns the FSM to IDLE at the next edge.
- While stall_i is high, nothing commits, and both state and cnt hold.
- A simultaneous ERET flag and pending interrupt on slot1 commits the interrupt; no ERET takes effect.

## Configuration
- EXC_TRAP_EN defined: the tr bit takes part in arbitration with code 0d.
- EXC_TRAP_EN undefined: the tr bit is ignored in both slots, and a slot whose only flag is tr commits nothing.

## Structure
- Shared package/header holds:
  - ExcCode constants: EXC_INT 00, ADEL 04, ADES 05, SYS 08, BP 09, RI 0a, OV 0c, TR 0d, ERET 0e.
  - Flag bit indices.
  - CP0_REG_EPC = 14.
  - EXC_VECTOR_OFS = 32'h180.
- One sub-module, exc_prio_enc: a 9-bit flag vector in, {hit, code[4:0]} out. It is instantiated once per slot.

## Test plan
- Slot1 valid, flags = ri|ov, ebase_i=32'hBFC00200 → same cycle: type 0a, first_inst 1, redirect_pc 32'hBFC00380, flush 1. busy_o goes high the next cycle for 2 cycles.
- Slot1 clean, slot2 ades, DRAIN_CYCLES=2 → type 05, first_inst 0. A slot1 adel_if presented in the next cycle is ignored; the same adel_if presented 3 cycles after the commit commits.
- Slot1 mtc0 EPC with cp0_wdata_i=32'h80001000, slot2 eret, epc_i=32'h0 → redirect_pc 32'h80001000, type 0e.
- IE=1, EXL=0, IM[2]=IP[2]=1 at edge N, slot1 valid → commit type 00 in cycle N+1. With EXL=1, no commit.
- Commit conditions met while stall_i=1 for 3 cycles → no outputs. The commit occurs in the first cycle with stall_i=0.
- tr-only flag on slot1 → type 0d with EXC_TRAP_EN defined; no commit without it.
